// File: rtl/wmem_pkg.sv
`default_nettype none
// ============================================================================
// wmem_pkg : packet layout, opcodes and FSM states for the weight dispatcher
// Rev 1.0
// ============================================================================
package wmem_pkg;

  localparam int WEIGHT_WIDTH = 8;
  localparam int IMEM_ID      = 11;

  localparam int PKT_W   = 33;
  localparam int DEST_HI = 32;
  localparam int DEST_LO = 29;
  localparam int OP_HI   = 28;
  localparam int OP_LO   = 25;
  localparam int DATA_HI = 24;
  localparam int DATA_LO = 0;

  localparam int DEST_W = DEST_HI - DEST_LO + 1;
  localparam int OP_W   = OP_HI - OP_LO + 1;
  localparam int DATA_W = DATA_HI - DATA_LO + 1;

  localparam logic [OP_W-1:0] OP_WEIGHT        = 4'd0;
  localparam logic [OP_W-1:0] OP_WEIGHTS_DONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_TIMESTEP_DONE = 4'd15;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND_A  = 3'd2,
    SEND_B  = 3'd3,
    SEND_DN = 3'd4,
    WAIT_TS = 3'd5,
    DONE    = 3'd6
  } state_t;

  function automatic pkt_t make_pkt(input logic [DEST_W-1:0] dest,
                                    input logic [OP_W-1:0]   op,
                                    input logic [DATA_W-1:0] data);
    pkt_t p;
    p.dest = dest;
    p.op   = op;
    p.data = data;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_store.sv
`default_nettype none
// ============================================================================
// weight_store : register file with one write port and NREAD consecutive
// combinational read ports starting at rbase.
// Rev 1.0
// ============================================================================
module weight_store #(
  parameter int DEPTH = 25,
  parameter int WIDTH = 8,
  parameter int NREAD = 5,
  parameter int AW    = 5
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [AW-1:0]               rbase,
  output logic [NREAD-1:0][WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Write forwarding lets the packet register capture a word written on the same edge.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx      = rbase + AW'(k);
    assign rdata[k] = (we && (waddr == idx)) ? wdata : mem_q[idx];
  end

endmodule
`default_nettype wire

// File: rtl/weight_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// weight_dispatch_ctrl : loads the filter weight store, disperses it to the PPE
// row as packets, then counts TIMESTEP_DONE packets until the run completes.
// Rev 1.0
// ============================================================================
module weight_dispatch_ctrl
  import wmem_pkg::*;
#(
  parameter int FILTER_SIZE   = 5,
  parameter int WEIGHT_WIDTH  = wmem_pkg::WEIGHT_WIDTH,
  parameter int FIRST_PPE     = 5,
  parameter int IMEM_ID       = wmem_pkg::IMEM_ID,
  parameter int NUM_TIMESTEPS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4:0]              ld_addr,
  input  logic [WEIGHT_WIDTH-1:0] ld_data,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [PKT_W-1:0]        pkt_out,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic [PKT_W-1:0]        rx_pkt,
  output logic                    busy,
  output logic                    done,
  output logic                    addr_err,
  output logic [1:0]              ts_count
);

  localparam int         DEPTH  = FILTER_SIZE * FILTER_SIZE;
  localparam int         AW     = 5;
  localparam logic [1:0] TS_MAX = 2'(NUM_TIMESTEPS);

  state_t                             state_q, state_d;
  logic [4:0]                         ld_cnt_q, ld_cnt_d;
  logic [2:0]                         row_q, row_d;
  logic [1:0]                         ts_count_q, ts_count_d;
  logic                               addr_err_q, addr_err_d;
  logic                               ld_ready_q, ld_ready_d;
  logic                               pkt_valid_q, pkt_valid_d;
  logic                               rx_ready_q, rx_ready_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  pkt_t                               pkt_q, pkt_d;
  logic                               store_we;
  logic [AW-1:0]                      rbase;
  logic [FILTER_SIZE-1:0][WEIGHT_WIDTH-1:0] rd;
  pkt_t                               rx_p;
  logic                               ld_xfer, pkt_xfer, rx_xfer;
  logic                               unused_rx;

  assign rx_p      = pkt_t'(rx_pkt);
  assign unused_rx = ^{rx_p.dest, rx_p.data};
  assign ld_xfer   = ld_valid && ld_ready_q;
  assign pkt_xfer  = pkt_valid_q && pkt_ready;
  assign rx_xfer   = rx_valid && rx_ready_q;

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    row_d      = row_q;
    ts_count_d = ts_count_q;
    addr_err_d = addr_err_q;
    store_we   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          ld_cnt_d   = '0;
          row_d      = '0;
          ts_count_d = '0;
          addr_err_d = 1'b0;
        end
      end
      LOAD: begin
        if (ld_xfer) begin
          // Out-of-range words still count toward the 25 transfers.
          if (ld_addr < AW'(DEPTH)) store_we = 1'b1;
          else                      addr_err_d = 1'b1;
          ld_cnt_d = ld_cnt_q + 5'd1;
          if (ld_cnt_q == 5'(DEPTH - 1)) state_d = SEND_A;
        end
      end
      SEND_A: if (pkt_xfer) state_d = SEND_B;
      SEND_B: begin
        if (pkt_xfer) begin
          row_d   = row_q + 3'd1;
          state_d = (row_q == 3'(FILTER_SIZE - 1)) ? SEND_DN : SEND_A;
        end
      end
      SEND_DN: if (pkt_xfer) state_d = WAIT_TS;
      WAIT_TS: begin
        if (rx_xfer && (rx_p.op == OP_TIMESTEP_DONE)) begin
          if (ts_count_q != TS_MAX) ts_count_d = ts_count_q + 2'd1;
          if (ts_count_q + 2'd1 == TS_MAX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rbase = (row_d < 3'(FILTER_SIZE)) ? AW'(row_d) * AW'(FILTER_SIZE) : '0;

  weight_store #(
    .DEPTH (DEPTH),
    .WIDTH (WEIGHT_WIDTH),
    .NREAD (FILTER_SIZE),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .rbase (rbase),
    .rdata (rd)
  );

  // Outputs are registered from the next state so they change with it.
  always_comb begin
    ld_ready_d  = (state_d == LOAD);
    rx_ready_d  = (state_d == WAIT_TS);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    pkt_valid_d = (state_d == SEND_A) || (state_d == SEND_B) || (state_d == SEND_DN);
    pkt_d       = '0;
    case (state_d)
      SEND_A:  pkt_d = make_pkt(DEST_W'(FIRST_PPE) + DEST_W'(row_d), OP_WEIGHT,
                                DATA_W'({rd[2], rd[1], rd[0]}));
      SEND_B:  pkt_d = make_pkt(DEST_W'(FIRST_PPE) + DEST_W'(row_d), OP_WEIGHT,
                                DATA_W'({rd[4], rd[3]}));
      SEND_DN: pkt_d = make_pkt(DEST_W'(IMEM_ID), OP_WEIGHTS_DONE, '0);
      default: pkt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      row_q       <= '0;
      ts_count_q  <= '0;
      addr_err_q  <= 1'b0;
      ld_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      row_q       <= row_d;
      ts_count_q  <= ts_count_d;
      addr_err_q  <= addr_err_d;
      ld_ready_q  <= ld_ready_d;
      pkt_valid_q <= pkt_valid_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pkt_q       <= pkt_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_out   = pkt_q;
  assign rx_ready  = rx_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;
  assign ts_count  = ts_count_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_weight_dispatch_ctrl : scoreboard bench; expected packets are queued by the
// stimulus and popped by a monitor whenever the DUT presents a packet.
// Rev 1.0
// ============================================================================
module tb_weight_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, ld_valid, pkt_ready, rx_valid;
  logic [4:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [32:0] rx_pkt;
  logic        ld_ready, pkt_valid, rx_ready, busy, done, addr_err;
  logic [32:0] pkt_out;
  logic [1:0]  ts_count;

  int n_checks   = 0;
  int n_fail     = 0;
  int pkt_seen   = 0;
  int stall_pkt  = -1;
  int stall_done = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  model [25];

  // Hand-computed row packets for w[k] = k+1
  logic [24:0] t1_a [5] = '{25'h030201, 25'h080706, 25'h0D0C0B, 25'h121110, 25'h171615};
  logic [24:0] t1_b [5] = '{25'h0000504, 25'h0000A09, 25'h0000F0E, 25'h0001413, 25'h0001918};

  always #5 clk = ~clk;

  weight_dispatch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_out   (pkt_out),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_pkt    (rx_pkt),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .ts_count  (ts_count)
  );

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ld_ready"},  33'(ld_ready),  33'd0);
    chk({tag, "_pkt_valid"}, 33'(pkt_valid), 33'd0);
    chk({tag, "_rx_ready"},  33'(rx_ready),  33'd0);
    chk({tag, "_busy"},      33'(busy),      33'd0);
    chk({tag, "_done"},      33'(done),      33'd0);
    chk({tag, "_addr_err"},  33'(addr_err),  33'd0);
    chk({tag, "_ts_count"},  33'(ts_count),  33'd0);
    chk({tag, "_pkt_out"},   pkt_out,        33'd0);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    pkt_seen = 0;
    chk("start_busy",     33'(busy),     33'd1);
    chk("start_ld_ready", 33'(ld_ready), 33'd1);
    chk("start_addr_err", 33'(addr_err), 33'd0);
    chk("start_ts_count", 33'(ts_count), 33'd0);
  endtask

  task automatic ld_word(input logic [4:0] a, input logic [7:0] d);
    int t = 0;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    while (!ld_ready && t < 50) begin
      tick();
      t++;
    end
    if (!ld_ready) fail_to("ld_ready_wait");
    tick();
    ld_valid = 1'b0;
    if (a < 5'd25) model[a] = d;
  endtask

  task automatic push_t1();
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back({4'(5 + r), 4'h0, t1_a[r]});
      exp_q.push_back({4'(5 + r), 4'h0, t1_b[r]});
    end
    exp_q.push_back({4'd11, 4'd0, 25'd0});
  endtask

  task automatic push_model();
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back({4'(5 + r), 4'h0, 1'b0, model[5*r+2], model[5*r+1], model[5*r]});
      exp_q.push_back({4'(5 + r), 4'h0, 9'd0, model[5*r+4], model[5*r+3]});
    end
    exp_q.push_back({4'd11, 4'd0, 25'd0});
  endtask

  task automatic wait_rx_ready();
    int t = 0;
    while (!rx_ready && t < 300) begin
      tick();
      t++;
    end
    if (!rx_ready) fail_to("rx_ready_wait");
  endtask

  task automatic end_of_stream(input string tag);
    chk({tag, "_pkt_count"},   33'(pkt_seen),     33'd11);
    chk({tag, "_queue_empty"}, 33'(exp_q.size()), 33'd0);
  endtask

  task automatic send_rx(input logic [3:0] op);
    int t = 0;
    rx_valid = 1'b1;
    rx_pkt   = {4'd3, op, 25'h1234};
    while (!rx_ready && t < 50) begin
      tick();
      t++;
    end
    if (!rx_ready) fail_to("rx_send_wait");
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    send_rx(4'd15);
    send_rx(4'd15);
    chk({tag, "_done"}, 33'(done), 33'd1);
  endtask

  // Router model: optionally stalls a chosen packet for three cycles
  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pkt_valid && pkt_seen == stall_pkt && stall_done < 3) begin
        pkt_ready = 1'b0;
        stall_done++;
      end else begin
        pkt_ready = 1'b1;
      end
    end
  end

  // Monitor: every presented packet must match the queue head; pop on transfer
  initial begin
    forever begin
      @(negedge clk);
      if (pkt_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pkt_unexpected: got %0h, want no packet (t=%0t)", pkt_out, $time);
        end else begin
          chk("pkt", pkt_out, exp_q[0]);
          if (pkt_ready) begin
            void'(exp_q.pop_front());
            pkt_seen++;
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int t;
    reset    = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    rx_valid = 1'b0;
    rx_pkt   = '0;
    for (int k = 0; k < 25; k++) model[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    reset = 1'b0;
    tick();

    // T1: in-order load, hand-computed packet stream
    start_run();
    for (int k = 0; k < 25; k++) ld_word(5'(k), 8'(k + 1));
    push_t1();
    wait_rx_ready();
    end_of_stream("t1");
    finish_run("t1");

    // T2: packet 4 stalled three cycles
    stall_pkt  = 3;
    stall_done = 0;
    start_run();
    for (int k = 0; k < 25; k++) ld_word(5'(k), 8'(k + 1));
    push_t1();
    wait_rx_ready();
    end_of_stream("t2");
    chk("t2_stall_cycles", 33'(stall_done), 33'd3);
    stall_pkt = -1;
    finish_run("t2");

    // T3: reverse order with gaps; store[7] written 0xAA then 0xBB; slot 3 keeps old value
    start_run();
    for (int a = 24; a >= 4; a--) begin
      ld_word(5'(a), (a == 7) ? 8'hAA : 8'(8'h40 + a));
      if (a % 3 == 0) repeat (2) tick();
    end
    for (int a = 2; a >= 0; a--) ld_word(5'(a), 8'(8'h40 + a));
    tick();
    ld_word(5'd7, 8'hBB);
    push_model();
    chk("t3_row1_a", exp_q[2], {4'd6, 4'd0, 25'hBB4645});
    wait_rx_ready();
    end_of_stream("t3");
    finish_run("t3");

    // T4: one out-of-range address among 25 transfers
    start_run();
    for (int k = 0; k < 25; k++) ld_word((k == 12) ? 5'd30 : 5'(k), 8'(8'h80 + k));
    chk("t4_addr_err",  33'(addr_err),  33'd1);
    chk("t4_left_load", 33'(ld_ready),  33'd0);
    chk("t4_pkt_valid", 33'(pkt_valid), 33'd1);
    push_model();
    wait_rx_ready();
    end_of_stream("t4");

    // T5: non-timestep opcode dropped, then two TIMESTEP_DONE packets
    chk("t5_ts0", 33'(ts_count), 33'd0);
    send_rx(4'd3);
    chk("t5_ts_after_op3",   33'(ts_count), 33'd0);
    chk("t5_done_after_op3", 33'(done),     33'd0);
    chk("t5_rx_ready_op3",   33'(rx_ready), 33'd1);
    send_rx(4'd15);
    chk("t5_ts1",   33'(ts_count), 33'd1);
    chk("t5_done1", 33'(done),     33'd0);
    send_rx(4'd15);
    chk("t5_ts2",       33'(ts_count), 33'd2);
    chk("t5_done2",     33'(done),     33'd1);
    chk("t5_busy",      33'(busy),     33'd0);
    chk("t5_rx_ready",  33'(rx_ready), 33'd0);
    chk("t5_addr_err",  33'(addr_err), 33'd1);

    // T6: asynchronous reset during SEND_B of row 2, then a full rerun
    start_run();
    for (int k = 0; k < 25; k++) ld_word(5'(k), 8'(8'hC0 + k));
    push_model();
    t = 0;
    while (!(pkt_valid && pkt_seen == 5) && t < 100) begin
      tick();
      t++;
    end
    if (!(pkt_valid && pkt_seen == 5)) fail_to("t6_reach_row2_b");
    chk("t6_pkt_before_reset", pkt_out, {4'd7, 4'd0, 9'd0, 8'hCE, 8'hCD});
    reset = 1'b1;
    #1;
    check_reset("t6_async");
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    start_run();
    for (int k = 0; k < 25; k++) ld_word(5'(k), 8'(8'h10 + 3 * k));
    push_model();
    wait_rx_ready();
    end_of_stream("t6");
    finish_run("t6");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
